// File: rtl/perm_board_gen_if.sv
// Bus bundle between a board consumer and perm_board_gen: game status, shuffle
// request and seeding in one direction; packed board, busy and done back.
interface perm_board_gen_if #(
   parameter int N = 4,
   parameter int W = 3
);
   logic [1:0]     game_status;
   logic           start;
   logic           seed_load;
   logic [15:0]    seed;
   logic [N*W-1:0] board;
   logic           busy;
   logic           done;

   modport master (
      output game_status, start, seed_load, seed,
      input  board, busy, done
   );

   modport slave (
      input  game_status, start, seed_load, seed,
      output board, busy, done
   );
endinterface

// File: rtl/perm_board_gen.sv
// Random board permutation generator: Fisher-Yates shuffle driven by a 16-bit Galois LFSR.
// Optional macro PARITY_FIX_EN adds a one-cycle FIX state that forces an even permutation.
module perm_board_gen #(
   parameter int N = 4,
   parameter int W = 3
) (
   input logic             clk_d,
   input logic             rst,
   perm_board_gen_if.slave bus
);
   localparam logic [15:0] LFSR_INIT      = 16'hACE1;
   localparam logic [15:0] LFSR_MASK      = 16'hB400;
   localparam logic [1:0]  GS_CHOSE_BOARD = 2'b00;
   localparam int          NW             = N * W;

`ifdef PARITY_FIX_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHUFFLE = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHUFFLE = 2'd1, DONE = 2'd3} state_t;
`endif

   function automatic logic [NW-1:0] identity();
      logic [NW-1:0] v;
      v = '0;
      for (int p = 0; p < N; p++) v[(N-1-p)*W +: W] = W'(p);
      return v;
   endfunction

   // Masked draw folded into 0..i; the fold keeps the choice in range without a divider.
   function automatic logic [3:0] swap_partner(input logic [3:0] i, input logic [3:0] r);
      logic [3:0] m;
      logic [3:0] c;
      if (i >= 4'd8)      m = 4'd15;
      else if (i >= 4'd4) m = 4'd7;
      else if (i >= 4'd2) m = 4'd3;
      else                m = 4'd1;
      c = r & m;
      if (c <= i) return c;
      return c - i - 4'd1;
   endfunction

   function automatic logic [NW-1:0] swap_tiles(input logic [NW-1:0] b, input int a, input int c);
      logic [NW-1:0] v;
      v = b;
      v[(N-1-a)*W +: W] = b[(N-1-c)*W +: W];
      v[(N-1-c)*W +: W] = b[(N-1-a)*W +: W];
      return v;
   endfunction

   state_t        state, state_nxt;
   logic [15:0]   lfsr;
   logic [3:0]    idx, idx_nxt, partner;
   logic [NW-1:0] board, board_nxt;
   logic          abort;
`ifdef PARITY_FIX_EN
   logic          parity, parity_nxt;
`endif

   // LFSR free-runs every cycle so seeding never depends on FSM state.
   always_ff @(posedge clk_d) begin
      if (rst)                lfsr <= LFSR_INIT;
      else if (bus.seed_load) lfsr <= (bus.seed == 16'h0000) ? LFSR_INIT : bus.seed;
      else                    lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
   end

   always_ff @(posedge clk_d) begin
      if (rst) begin
         state  <= IDLE;
         board  <= identity();
         idx    <= '0;
`ifdef PARITY_FIX_EN
         parity <= 1'b0;
`endif
      end else begin
         state  <= state_nxt;
         board  <= board_nxt;
         idx    <= idx_nxt;
`ifdef PARITY_FIX_EN
         parity <= parity_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt  = state;
      board_nxt  = board;
      idx_nxt    = idx;
`ifdef PARITY_FIX_EN
      parity_nxt = parity;
`endif
      abort      = (bus.game_status != GS_CHOSE_BOARD);
      partner    = swap_partner(idx, lfsr[3:0]);
      case (state)
         IDLE: begin
            if (abort) begin
               board_nxt = identity();
            end else if (bus.start) begin
               state_nxt  = SHUFFLE;
               idx_nxt    = 4'(N - 1);
               board_nxt  = identity();
`ifdef PARITY_FIX_EN
               parity_nxt = 1'b0;
`endif
            end
         end
         SHUFFLE: begin
            if (abort) begin
               state_nxt = IDLE;
               board_nxt = identity();
            end else begin
               board_nxt = swap_tiles(board, int'(idx), int'(partner));
               idx_nxt   = idx - 4'd1;
`ifdef PARITY_FIX_EN
               parity_nxt = parity ^ (partner != idx);
               if (idx == 4'd1) state_nxt = FIX;
`else
               if (idx == 4'd1) state_nxt = DONE;
`endif
            end
         end
`ifdef PARITY_FIX_EN
         FIX: begin
            if (abort) begin
               state_nxt = IDLE;
               board_nxt = identity();
            end else begin
               if (parity) board_nxt = swap_tiles(board, 0, 1);
               state_nxt = DONE;
            end
         end
`endif
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.board = board;
   assign bus.done  = (state == DONE);
`ifdef PARITY_FIX_EN
   assign bus.busy  = (state == SHUFFLE) || (state == FIX);
`else
   assign bus.busy  = (state == SHUFFLE);
`endif
endmodule

// File: tb/tb_perm_board_gen.sv
// Self-checking bench for perm_board_gen: a permutation-level reference model plus
// directed scenarios (seeding, repeatability, abort, reset, start while busy).
module tb_perm_board_gen;
  localparam int N  = 4;
  localparam int W  = 3;
  localparam int NW = N * W;
  localparam logic [15:0]   LFSR_INIT = 16'hACE1;
  localparam logic [NW-1:0] IDENT     = 12'h053;
`ifdef PARITY_FIX_EN
  localparam int            BUSY_LEN  = N;
  localparam logic [NW-1:0] ODD_SEED_BOARD = 12'h4C1;
  localparam int            ODD_SEED_PARITY = 0;
`else
  localparam int            BUSY_LEN  = N - 1;
  localparam logic [NW-1:0] ODD_SEED_BOARD = 12'h681;
  localparam int            ODD_SEED_PARITY = 1;
`endif

  logic clk_d = 1'b0;
  logic rst   = 1'b1;
  perm_board_gen_if #(.N(N), .W(W)) bus();
  perm_board_gen #(.N(N), .W(W)) dut (.clk_d(clk_d), .rst(rst), .bus(bus));

  always #5 clk_d = ~clk_d;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int inv_count(input logic [NW-1:0] b);
    int n = 0;
    for (int a = 0; a < N; a++)
      for (int c = a + 1; c < N; c++)
        if (b[(N-1-a)*W +: W] > b[(N-1-c)*W +: W]) n++;
    return n;
  endfunction

  function automatic bit is_perm(input logic [NW-1:0] b);
    bit seen[N];
    int v;
    for (int k = 0; k < N; k++) seen[k] = 1'b0;
    for (int k = 0; k < N; k++) begin
      v = int'(b[(N-1-k)*W +: W]);
      if (v >= N || seen[v]) return 1'b0;
      seen[v] = 1'b1;
    end
    return 1'b1;
  endfunction

  // Final board for a shuffle whose first swap sees LFSR value 'first'.
  function automatic logic [NW-1:0] shuffle_result(input logic [15:0] first);
    int p[N];
    int m, c, j, t;
    logic [15:0] l;
    logic [NW-1:0] r;
    for (int k = 0; k < N; k++) p[k] = k;
    l = first;
    for (int i = N - 1; i >= 1; i--) begin
      m = 1;
      while (m < i) m = m * 2 + 1;
      c = int'(l[3:0]) & m;
      j = (c <= i) ? c : c - (i + 1);
      t = p[i]; p[i] = p[j]; p[j] = t;
      l = lfsr_step(l);
    end
    r = '0;
    for (int k = 0; k < N; k++) r[(N-1-k)*W +: W] = W'(p[k]);
`ifdef PARITY_FIX_EN
    if (inv_count(r) % 2 == 1) begin
      t = p[0]; p[0] = p[1]; p[1] = t;
      for (int k = 0; k < N; k++) r[(N-1-k)*W +: W] = W'(p[k]);
    end
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks cycles since an accepted start.
  logic [15:0]   m_lfsr  = LFSR_INIT;
  logic [15:0]   m_nxt;
  logic [NW-1:0] m_board = IDENT;
  logic [NW-1:0] m_final = IDENT;
  int            since   = 0;

  always @(posedge clk_d) begin
    if (rst) begin
      m_lfsr = LFSR_INIT; since = 0; m_board = IDENT;
    end else begin
      m_nxt = bus.seed_load ? ((bus.seed == 16'h0000) ? LFSR_INIT : bus.seed) : lfsr_step(m_lfsr);
      if (since == 0) begin
        if (bus.game_status != 2'b00) m_board = IDENT;
        else if (bus.start) begin
          m_final = shuffle_result(m_nxt); since = 1; m_board = IDENT;
        end
      end else if (since <= BUSY_LEN) begin
        if (bus.game_status != 2'b00) begin
          since = 0; m_board = IDENT;
        end else begin
          since++;
          if (since == BUSY_LEN + 1) m_board = m_final;
        end
      end else begin
        since = 0;
      end
      m_lfsr = m_nxt;
    end
  end

  always @(negedge clk_d) begin
    if (chk_en) begin
      check("busy", 16'(bus.busy), 16'(since >= 1 && since <= BUSY_LEN));
      check("done", 16'(bus.done), 16'(since == BUSY_LEN + 1));
      if (!(since >= 1 && since <= BUSY_LEN)) check("board", 16'(bus.board), 16'(m_board));
      check("is_perm", 16'(is_perm(bus.board)), 16'd1);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_d);
    #1;
  endtask

  task automatic wait_done(input int limit, output logic [NW-1:0] b, output int busy_cycles);
    busy_cycles = 0;
    b = '0;
    for (int k = 0; k < limit; k++) begin
      if (bus.done) begin
        b = bus.board;
        return;
      end
      if (bus.busy) busy_cycles++;
      tick();
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_done: no done within %0d cycles, got busy=%0b expected done=1", limit, bus.busy);
  endtask

  logic [NW-1:0] b;
  logic [NW-1:0] rb[2];
  int            bc;
  logic [15:0]   seeds[5] = '{16'hBEEF, 16'h0001, 16'h8000, 16'hFFFF, 16'h5A5A};

  initial begin
    bus.game_status = 2'b01;
    bus.start = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed = 16'h0000;
    rst = 1'b1;
    @(posedge clk_d); #1;
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick(2);
    check("rst_board", 16'(bus.board), 16'h053);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_done", 16'(bus.done), 16'd0);

    // start outside CHOSE_BOARD is ignored
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    check("start_ignored", 16'(bus.busy), 16'd0);
    tick();

    // seed 0 loads ACE1 in the same cycle as start
    bus.game_status = 2'b00;
    bus.seed = 16'h0000; bus.seed_load = 1'b1; bus.start = 1'b1;
    tick();
    bus.seed_load = 1'b0; bus.start = 1'b0;
    wait_done(20, b, bc);
    check("odd_seed_board", 16'(b), 16'(ODD_SEED_BOARD));
    check("odd_seed_busy_cycles", 16'(bc), 16'(BUSY_LEN));
    check("odd_seed_parity", 16'(inv_count(b) % 2), 16'(ODD_SEED_PARITY));
    check("model_pin_ace1", 16'(shuffle_result(16'hACE1)), 16'(ODD_SEED_BOARD));
    tick();
    check("done_single", 16'(bus.done), 16'd0);
    tick(2);

    // identical seed and timing give identical boards
    for (int r = 0; r < 2; r++) begin
      bus.seed = 16'h1234; bus.seed_load = 1'b1; tick(); bus.seed_load = 1'b0;
      tick(2);
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      wait_done(20, rb[r], bc);
      tick(2);
    end
    check("repeat_same", 16'(rb[1]), 16'(rb[0]));

    for (int s = 0; s < 5; s++) begin
      bus.seed = seeds[s]; bus.seed_load = 1'b1; bus.start = 1'b1;
      tick();
      bus.seed_load = 1'b0; bus.start = 1'b0;
      wait_done(20, b, bc);
      check("seed_board", 16'(b), 16'(shuffle_result(seeds[s])));
      tick(3);
      check("hold_board", 16'(bus.board), 16'(b));
    end

    // game_status leaves CHOSE_BOARD during the 2nd shuffle cycle
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick();
    bus.game_status = 2'b01;
    tick();
    check("abort_busy", 16'(bus.busy), 16'd0);
    check("abort_board", 16'(bus.board), 16'h053);
    check("abort_done", 16'(bus.done), 16'd0);
    tick(3);
    bus.game_status = 2'b00;
    tick();

    // reset with start held during the 2nd shuffle cycle
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick();
    rst = 1'b1; bus.start = 1'b1;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    check("rst_mid_board", 16'(bus.board), 16'h053);
    check("rst_mid_busy", 16'(bus.busy), 16'd0);
    tick(2);

    // start held into the first shuffle cycle is not a second request
    bus.start = 1'b1; tick(); tick(); bus.start = 1'b0;
    wait_done(20, b, bc);
    check("busy_start_cycles", 16'(bc), 16'(BUSY_LEN - 1));
    tick();
    check("busy_start_no_relaunch", 16'(bus.busy), 16'd0);
    tick(2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/perm_board_gen.md
PERM_BOARD_GEN -- requirements
Module: perm_board_gen

Interface
REQ-001 SHALL have parameter N, default 4: number of board positions/tiles, 2..16.
REQ-002 SHALL have parameter W, default 3: bits per tile field, 2^W >= N.
REQ-003 SHALL have port clk_d  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port game_status  input  2: 2'b00 CHOSE_BOARD, 2'b01 GAMING, 2'b10 GAME_INITIAL, 2'b11 WINNED.
REQ-006 SHALL have port start  input  1: one-cycle request to shuffle the board.
REQ-007 SHALL have port seed_load  input  1: load seed into the LFSR.
REQ-008 SHALL have port seed  input  16: LFSR seed value.
REQ-009 SHALL have port board  output N*W: position p at bits [(N-1-p)*W +: W], holding a tile value 0..N-1.
REQ-010 SHALL have port busy  output 1: high while in SHUFFLE or FIX.
REQ-011 SHALL have port done  output 1: one-cycle pulse when a new board is complete.

Function
REQ-012 SHALL hold identity as the board value with position p = p (N=4,W=3: 12'h053).
REQ-013 SHALL run a 16-bit Galois LFSR every cycle (mask 16'hB400); seed_load loads seed, with seed 16'h0000 loaded as 16'hACE1.
REQ-014 SHALL implement states IDLE, SHUFFLE, FIX, DONE.
REQ-015 IDLE: game_status != 2'b00 forces board to identity each cycle; start is accepted only when game_status == 2'b00 and is ignored otherwise.
REQ-016 Accepted start SHALL set index i = N-1, parity = 0, board = identity, and enter SHUFFLE next cycle.
REQ-017 SHUFFLE, one swap per cycle: c = LFSR[3:0] AND m(i), where m(i) = smallest 2^k-1 >= i; j = c if c <= i, else c-(i+1); swap positions i and j.
REQ-018 Parity SHALL toggle on every swap with j != i.
REQ-019 i SHALL decrement after each swap; the swap at i=1 SHALL be the last, giving exactly N-1 SHUFFLE cycles.
REQ-020 After the last swap: go to FIX if PARITY_FIX_EN is defined, else to DONE.
REQ-021 DONE: done=1 for one cycle, then IDLE; board SHALL hold its value while game_status == 2'b00.
REQ-022 start while busy SHALL be ignored.
REQ-023 game_status leaving 2'b00 during SHUFFLE/FIX SHALL abort to IDLE next cycle with board = identity and no done pulse.
REQ-024 seed_load and start in the same cycle: seed SHALL be loaded, and the shuffle SHALL use the seeded LFSR from its first SHUFFLE cycle.
REQ-025 board SHALL always be a permutation of 0..N-1; unused upper field bits SHALL be 0.

Reset
REQ-026 rst SHALL force state IDLE, board = identity, busy=0, done=0, parity=0, LFSR=16'hACE1.
REQ-027 rst asserted mid-shuffle SHALL take priority over every input and discard the partial board.

Configuration
REQ-028 Macro PARITY_FIX_EN SHALL control parity correction.
REQ-029 With PARITY_FIX_EN defined: in FIX (1 cycle), odd parity SHALL swap positions 0 and 1, making the permutation even; even parity SHALL leave the board unchanged; total latency from start to done is N+1 cycles.
REQ-030 Without PARITY_FIX_EN: the FIX state and parity logic SHALL be absent; latency from start to done is N cycles; the board may be odd.

Verification
REQ-031 Reset, then game_status=2'b01 -> board=12'h053, busy=0, done=0.
REQ-032 N=4, seed_load with seed=16'h0000, then start -> LFSR=16'hACE1; busy for 3 cycles (4 with PARITY_FIX_EN); single done pulse; board is a valid permutation.
REQ-033 Same seed and start timing repeated twice -> identical board values both runs.
REQ-034 PARITY_FIX_EN, forced odd-parity sequence -> final board has even inversion count; without the macro, the same stimulus yields the odd board.
REQ-035 game_status -> 2'b01 on the 2nd SHUFFLE cycle -> IDLE next cycle, board=12'h053, no done pulse.
REQ-036 rst on the 2nd SHUFFLE cycle -> next cycle board=12'h053, busy=0; start while busy -> ignored.
